// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result path: control code constants, the
// write-back sequencer state enum, and small decode helpers used by both the
// instruction decoder and the write-back sequencer.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int CTRL_W = 4;

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam ctrl_t ALU_ADD   = 4'h1;
    localparam ctrl_t ALU_SUB   = 4'h2;
    localparam ctrl_t ALU_MUL   = 4'h4;
    localparam ctrl_t ALU_DIV   = 4'h8;
    localparam ctrl_t ALU_ANDI  = 4'hC;
    localparam ctrl_t ALU_ORI   = 4'hE;
    localparam ctrl_t ALU_ADDNF = 4'hF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } seq_state_t;

    // MUL and DIV produce a secondary result that lands in R0.
    function automatic logic is_two_write(input ctrl_t ctrl);
        return (ctrl == ALU_MUL) || (ctrl == ALU_DIV);
    endfunction

    // Only the add/subtract family suppresses its write on overflow.
    function automatic logic is_ovf_checked(input ctrl_t ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB) || (ctrl == ALU_ADDNF);
    endfunction

    // Logic-immediate operations always write and never overflow.
    function automatic logic is_logic_imm(input ctrl_t ctrl);
        return (ctrl == ALU_ANDI) || (ctrl == ALU_ORI);
    endfunction

endpackage

// File: rtl/alu_wb_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_wb_sequencer_if
// Handshake bundle between the execute stage and the write-back sequencer.
//   in_valid  : execute presents a completed operation
//   in_ready  : sequencer can accept (transfer on valid && ready)
//   in_ctrl   : ALU control code
//   in_rd     : destination register
//   in_result : primary result
//   in_r0     : secondary result (high product / remainder)
//   in_ovf    : ALU overflow flag for this operation
// master = execute stage, slave = sequencer.
// ---------------------------------------------------------------------------
interface alu_wb_sequencer_if
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);

    logic              in_valid;
    logic              in_ready;
    ctrl_t             in_ctrl;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_result;
    logic [DATA_W-1:0] in_r0;
    logic              in_ovf;

    modport master (
        output in_valid,
        input  in_ready,
        output in_ctrl,
        output in_rd,
        output in_result,
        output in_r0,
        output in_ovf
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_ctrl,
        input  in_rd,
        input  in_result,
        input  in_r0,
        input  in_ovf
    );

endinterface

// File: rtl/alu_wb_sequencer.sv
// ---------------------------------------------------------------------------
// alu_wb_sequencer
// Sequences completed ALU operations into a single-write-port register file.
// Single-result operations write once; MUL/DIV write the primary result to
// Rd and then the secondary result to R0 on the following cycle, stalling
// execute for that one cycle.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   exe         : execute-side handshake (slave modport)
//   wr_en       : register file write strobe
//   wr_addr     : register file write address
//   wr_data     : register file write data
//   ovf_pulse   : one-cycle pulse when an overflowing op retires
//   ovf_sticky  : sticky overflow status
//   ovf_clr     : clears ovf_sticky (a simultaneous new overflow wins)
//   retire_cnt  : 16-bit wrapping count of accepted operations
// ---------------------------------------------------------------------------
module alu_wb_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int R0_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    alu_wb_sequencer_if.slave exe,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              ovf_pulse,
    output logic              ovf_sticky,
    input  logic              ovf_clr,
    output logic [15:0]       retire_cnt
);

    localparam logic [ADDR_W-1:0] R0 = ADDR_W'(R0_ADDR);

    seq_state_t        state;
    seq_state_t        state_next;
    logic              ready;
    logic              xfer;
    logic [DATA_W-1:0] r0_hold;
    logic [DATA_W-1:0] r0_hold_next;
    logic              wr_en_next;
    logic [ADDR_W-1:0] wr_addr_next;
    logic [DATA_W-1:0] wr_data_next;
    logic              ovf_pulse_next;
    logic              ovf_sticky_next;
    logic [15:0]       retire_cnt_next;

    // Execute is only stalled during the R0 write slot.
    assign ready        = (state == ST_IDLE);
    assign exe.in_ready = ready;
    assign xfer         = exe.in_valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            r0_hold    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            ovf_pulse  <= 1'b0;
            ovf_sticky <= 1'b0;
            retire_cnt <= '0;
        end else begin
            state      <= state_next;
            r0_hold    <= r0_hold_next;
            wr_en      <= wr_en_next;
            wr_addr    <= wr_addr_next;
            wr_data    <= wr_data_next;
            ovf_pulse  <= ovf_pulse_next;
            ovf_sticky <= ovf_sticky_next;
            retire_cnt <= retire_cnt_next;
        end
    end

    // Address/data hold their last value when no write is issued so the
    // register file bus only toggles on real writes.
    always_comb begin
        state_next     = state;
        r0_hold_next   = r0_hold;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr;
        wr_data_next   = wr_data;
        ovf_pulse_next = 1'b0;

        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    if (is_two_write(exe.in_ctrl)) begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = exe.in_rd;
                        wr_data_next = exe.in_result;
                        r0_hold_next = exe.in_r0;
                        state_next   = ST_SECOND;
                    end else if (is_ovf_checked(exe.in_ctrl)) begin
                        if (exe.in_ovf) begin
                            ovf_pulse_next = 1'b1;
                        end else begin
                            wr_en_next   = 1'b1;
                            wr_addr_next = exe.in_rd;
                            wr_data_next = exe.in_result;
                        end
                    end else if (is_logic_imm(exe.in_ctrl)) begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = exe.in_rd;
                        wr_data_next = exe.in_result;
                    end
                end
            end
            ST_SECOND: begin
                wr_en_next   = 1'b1;
                wr_addr_next = R0;
                wr_data_next = r0_hold;
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // A new overflow takes priority over a clear arriving in the same cycle.
    always_comb begin
        ovf_sticky_next = ovf_sticky;
        if (ovf_pulse_next) begin
            ovf_sticky_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_next = 1'b0;
        end
    end

    // Every accepted operation counts, including dropped and overflowing ones.
    always_comb begin
        retire_cnt_next = retire_cnt;
        if (xfer) begin
            retire_cnt_next = retire_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_wb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_wb_sequencer
// Self-checking bench for alu_wb_sequencer: directed scenarios with constant
// expectations plus a randomized run against a per-operation reference model.
// ---------------------------------------------------------------------------
module tb_alu_wb_sequencer;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 4;
    localparam int R0_ADDR = 0;

    logic              clk;
    logic              rst;
    logic              ovf_clr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              ovf_pulse;
    logic              ovf_sticky;
    logic [15:0]       retire_cnt;

    int vectors;
    int miscompares;

    // Reference model state: expected registered outputs after each edge.
    bit                m_pend;
    logic [DATA_W-1:0] m_pend_val;
    logic              exp_ready;
    logic              exp_wr_en;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              exp_pulse;
    logic              exp_sticky;
    logic [15:0]       exp_cnt;

    alu_wb_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) exe ();

    alu_wb_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .R0_ADDR(R0_ADDR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .exe       (exe.slave),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ovf_pulse (ovf_pulse),
        .ovf_sticky(ovf_sticky),
        .ovf_clr   (ovf_clr),
        .retire_cnt(retire_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge, update the model from the inputs seen at that
    // edge, then settle 1 time unit past the edge before anyone samples.
    task automatic tick();
        bit xfer;
        @(posedge clk);
        if (rst) begin
            m_pend     = 1'b0;
            exp_ready  = 1'b1;
            exp_wr_en  = 1'b0;
            exp_addr   = '0;
            exp_data   = '0;
            exp_pulse  = 1'b0;
            exp_sticky = 1'b0;
            exp_cnt    = '0;
        end else begin
            xfer      = exe.in_valid && exp_ready;
            exp_wr_en = 1'b0;
            exp_pulse = 1'b0;
            if (m_pend) begin
                exp_wr_en = 1'b1;
                exp_addr  = ADDR_W'(R0_ADDR);
                exp_data  = m_pend_val;
                m_pend    = 1'b0;
            end else if (xfer) begin
                case (exe.in_ctrl)
                    4'h1, 4'h2, 4'hF: begin
                        if (exe.in_ovf) exp_pulse = 1'b1;
                        else begin
                            exp_wr_en = 1'b1;
                            exp_addr  = exe.in_rd;
                            exp_data  = exe.in_result;
                        end
                    end
                    4'hC, 4'hE: begin
                        exp_wr_en = 1'b1;
                        exp_addr  = exe.in_rd;
                        exp_data  = exe.in_result;
                    end
                    4'h4, 4'h8: begin
                        exp_wr_en  = 1'b1;
                        exp_addr   = exe.in_rd;
                        exp_data   = exe.in_result;
                        m_pend     = 1'b1;
                        m_pend_val = exe.in_r0;
                    end
                    default: ;
                endcase
            end
            if (xfer) exp_cnt = exp_cnt + 16'd1;
            if (exp_pulse) exp_sticky = 1'b1;
            else if (ovf_clr) exp_sticky = 1'b0;
            exp_ready = !m_pend;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [ADDR_W-1:0] rd,
                         input logic [DATA_W-1:0] res, input logic [DATA_W-1:0] r0, input logic ovf);
        exe.in_valid  = v;
        exe.in_ctrl   = c;
        exe.in_rd     = rd;
        exe.in_result = res;
        exe.in_r0     = r0;
        exe.in_ovf    = ovf;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 4'h0, '0, '0, '0, 1'b0);
        ovf_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        vectors++;
        if (exe.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", exe.in_ready); end
        vectors++;
        if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr_en: got %b expected 0", wr_en); end
        vectors++;
        if (wr_addr !== '0 || wr_data !== '0) begin miscompares++; $display("[TB] FAIL reset_wr_bus: got addr %0h data %0h expected 0/0", wr_addr, wr_data); end
        vectors++;
        if (ovf_pulse !== 1'b0 || ovf_sticky !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf: got pulse %b sticky %b expected 0/0", ovf_pulse, ovf_sticky); end
        vectors++;
        if (retire_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_cnt: got %0d expected 0", retire_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        do_reset();
        drive(1'b1, 4'h1, 4'd3, 16'h0005, 16'h0000, 1'b0);
        tick();
        idle_inputs();
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd3 || wr_data !== 16'h0005) begin miscompares++; $display("[TB] FAIL add_write: got en %b addr %0h data %0h expected 1/3/0005", wr_en, wr_addr, wr_data); end
        vectors++;
        if (retire_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL add_cnt: got %0d expected 1", retire_cnt); end
        tick();
        vectors++;
        if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL add_single_write: got %b expected 0", wr_en); end
    endtask

    task automatic test_mul_stall();
        do_reset();
        drive(1'b1, 4'h4, 4'd2, 16'h2000, 16'h0001, 1'b0);
        tick();
        // Hold a second operation valid across the stall slot.
        drive(1'b1, 4'h1, 4'd7, 16'h1234, 16'h0000, 1'b0);
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd2 || wr_data !== 16'h2000) begin miscompares++; $display("[TB] FAIL mul_first: got en %b addr %0h data %0h expected 1/2/2000", wr_en, wr_addr, wr_data); end
        vectors++;
        if (exe.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL mul_stall_ready: got %b expected 0", exe.in_ready); end
        tick();
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 16'h0001) begin miscompares++; $display("[TB] FAIL mul_second: got en %b addr %0h data %0h expected 1/0/0001", wr_en, wr_addr, wr_data); end
        vectors++;
        if (exe.in_ready !== 1'b1 || retire_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL mul_after_stall: got ready %b cnt %0d expected 1/1", exe.in_ready, retire_cnt); end
        tick();
        idle_inputs();
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd7 || wr_data !== 16'h1234 || retire_cnt !== 16'd2) begin miscompares++; $display("[TB] FAIL mul_held_op: got en %b addr %0h data %0h cnt %0d expected 1/7/1234/2", wr_en, wr_addr, wr_data, retire_cnt); end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(1'b1, 4'h2, 4'd5, 16'h7777, 16'h0000, 1'b1);
        tick();
        idle_inputs();
        vectors++;
        if (wr_en !== 1'b0 || ovf_pulse !== 1'b1 || ovf_sticky !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_sub: got en %b pulse %b sticky %b expected 0/1/1", wr_en, ovf_pulse, ovf_sticky); end
        tick();
        vectors++;
        if (ovf_pulse !== 1'b0 || ovf_sticky !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_pulse_len: got pulse %b sticky %b expected 0/1", ovf_pulse, ovf_sticky); end
        drive(1'b1, 4'h1, 4'd6, 16'h1111, 16'h0000, 1'b1);
        ovf_clr = 1'b1;
        tick();
        idle_inputs();
        vectors++;
        if (ovf_pulse !== 1'b1 || ovf_sticky !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_set_wins: got pulse %b sticky %b expected 1/1", ovf_pulse, ovf_sticky); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        vectors++;
        if (ovf_sticky !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_clear: got %b expected 0", ovf_sticky); end
        // Overflow flag on a logic op is ignored: it must write.
        drive(1'b1, 4'hE, 4'd9, 16'hABCD, 16'h0000, 1'b1);
        tick();
        idle_inputs();
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd9 || wr_data !== 16'hABCD || ovf_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL ori_ovf_ignored: got en %b addr %0h data %0h pulse %b expected 1/9/abcd/0", wr_en, wr_addr, wr_data, ovf_pulse); end
    endtask

    task automatic test_div_rd0();
        do_reset();
        drive(1'b1, 4'h8, 4'd0, 16'h0007, 16'h0003, 1'b0);
        tick();
        idle_inputs();
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 16'h0007) begin miscompares++; $display("[TB] FAIL div_first: got en %b addr %0h data %0h expected 1/0/0007", wr_en, wr_addr, wr_data); end
        tick();
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 16'h0003) begin miscompares++; $display("[TB] FAIL div_second: got en %b addr %0h data %0h expected 1/0/0003", wr_en, wr_addr, wr_data); end
        drive(1'b1, 4'hD, 4'd4, 16'hFFFF, 16'h0000, 1'b0);
        tick();
        idle_inputs();
        vectors++;
        if (wr_en !== 1'b0 || retire_cnt !== 16'd2) begin miscompares++; $display("[TB] FAIL unused_ctrl: got en %b cnt %0d expected 0/2", wr_en, retire_cnt); end
    endtask

    task automatic test_reset_in_second();
        do_reset();
        drive(1'b1, 4'h4, 4'd1, 16'h00AA, 16'h00BB, 1'b1);
        tick();
        idle_inputs();
        drive(1'b1, 4'h1, 4'd3, 16'h0001, 16'h0000, 1'b1);
        ovf_clr = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        vectors++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || ovf_pulse !== 1'b0 || ovf_sticky !== 1'b0 || retire_cnt !== 16'd0 || exe.in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_second: got en %b addr %0h data %0h pulse %b sticky %b cnt %0d ready %b expected all reset values", wr_en, wr_addr, wr_data, ovf_pulse, ovf_sticky, retire_cnt, exe.in_ready);
        end
        tick();
        vectors++;
        if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_second_no_r0: got %b expected 0", wr_en); end
    endtask

    task automatic test_random();
        logic [3:0] codes [8];
        codes = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hE, 4'hF, 4'h5};
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 4) != 0) ? codes[$urandom_range(0, 7)] : 4'($urandom_range(0, 15)),
                  ADDR_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
                  $urandom_range(0, 2) == 0);
            ovf_clr = $urandom_range(0, 9) == 0;
            rst     = $urandom_range(0, 49) == 0;
            tick();
            vectors++;
            if (exe.in_ready !== exp_ready) begin miscompares++; $display("[TB] FAIL rnd_ready[%0d]: got %b expected %b", i, exe.in_ready, exp_ready); end
            vectors++;
            if (wr_en !== exp_wr_en || (exp_wr_en && (wr_addr !== exp_addr || wr_data !== exp_data))) begin
                miscompares++;
                $display("[TB] FAIL rnd_write[%0d]: got en %b addr %0h data %0h expected %b/%0h/%0h", i, wr_en, wr_addr, wr_data, exp_wr_en, exp_addr, exp_data);
            end
            vectors++;
            if (ovf_pulse !== exp_pulse || ovf_sticky !== exp_sticky) begin miscompares++; $display("[TB] FAIL rnd_ovf[%0d]: got pulse %b sticky %b expected %b/%b", i, ovf_pulse, ovf_sticky, exp_pulse, exp_sticky); end
            vectors++;
            if (retire_cnt !== exp_cnt) begin miscompares++; $display("[TB] FAIL rnd_cnt[%0d]: got %0d expected %0d", i, retire_cnt, exp_cnt); end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 4'hC, 4'd1, 16'h0F0F, 16'h0000, 1'b0);
        for (int i = 0; i < 65535; i++) tick();
        vectors++;
        if (retire_cnt !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL wrap_max: got %0h expected ffff", retire_cnt); end
        tick();
        idle_inputs();
        vectors++;
        if (retire_cnt !== 16'h0000) begin miscompares++; $display("[TB] FAIL wrap_zero: got %0h expected 0", retire_cnt); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_pend      = 1'b0;
        m_pend_val  = '0;
        exp_ready   = 1'b1;
        exp_wr_en   = 1'b0;
        exp_addr    = '0;
        exp_data    = '0;
        exp_pulse   = 1'b0;
        exp_sticky  = 1'b0;
        exp_cnt     = '0;
        rst         = 1'b1;
        idle_inputs();
        test_reset();
        test_add();
        test_mul_stall();
        test_overflow();
        test_div_rd0();
        test_reset_in_second();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_wb_sequencer.md
# alu_wb_sequencer

Result-side counterpart of the datapath ALU. Accepts one completed ALU operation per handshake (control code, destination register, primary result, secondary R0 result, overflow indication) and sequences it into the single-write-port register file. Multiply and divide produce two results, so they take two consecutive write cycles: primary to Rd, secondary to R0. The block sits between the execute stage and the register file, and back-pressures execute while a two-write operation drains.

## Interface
- `DATA_W`, default 16, register and result width
- `ADDR_W`, default 4, register file address width
- `R0_ADDR`, default 0, register file address of R0

- `clk`, in, 1, rising-edge clock
- `rst`, in, 1, synchronous, active-high reset
- `in_valid`, in, 1, execute presents an operation
- `in_ready`, out, 1, block can accept; transfer when `in_valid && in_ready`
- `in_ctrl`, in, 4, ALU control code of the operation
- `in_rd`, in, ADDR_W, destination register
- `in_result`, in, DATA_W, primary ALU result (sum/difference/low product/quotient/logic)
- `in_r0`, in, DATA_W, secondary result (high product or remainder)
- `in_ovf`, in, 1, ALU overflow for this operation
- `wr_en`, out, 1, register file write strobe
- `wr_addr`, out, ADDR_W, register file write address
- `wr_data`, out, DATA_W, register file write data
- `ovf_pulse`, out, 1, one-cycle pulse when an overflowing operation is retired
- `ovf_sticky`, out, 1, sticky overflow status
- `ovf_clr`, in, 1, clears `ovf_sticky`
- `retire_cnt`, out, 16, count of accepted operations, wraps 0xFFFF→0

## Operation
- Control codes: 1 ADD, 2 SUB, 4 MUL, 8 DIV, C ANDI, E ORI, F ADD-no-func.
- State machine has two states. IDLE: `in_ready`=1. SECOND: `in_ready`=0.
- In IDLE, on a transfer with ctrl 1/2/F and `in_ovf`=0, or ctrl C/E: write `in_result` to `in_rd`. Stay in IDLE.
- In IDLE, on a transfer with ctrl 1/2/F and `in_ovf`=1: no write. Assert `ovf_pulse` and set `ovf_sticky`. Stay in IDLE. `in_ovf` is ignored for all other codes.
- In IDLE, on a transfer with ctrl 4/8: write `in_result` to `in_rd`, latch `in_r0`, and go to SECOND. In SECOND, write the latched value to `R0_ADDR` and return to IDLE.
- If Rd equals `R0_ADDR` on MUL/DIV, both writes are issued in order, so R0 ends holding the secondary result.
- Any other ctrl code (0, 3, 5–7, 9–B, D) is accepted and dropped with no write.
- `retire_cnt` increments on every transfer, including dropped and overflowing operations.
- `ovf_clr` and a new overflow in the same cycle: the set wins.

## Timing
- All outputs are registered except `in_ready`, which is decoded from state.
- Transfer at edge N → `wr_en`/`wr_addr`/`wr_data` valid in the cycle after edge N (latency 1). For MUL/DIV the R0 write follows in the next cycle.
- Back-to-back single-write operations sustain one per cycle. A MUL/DIV costs two cycles; `in_ready` is low for exactly one cycle.
- `ovf_pulse` has the same latency as `wr_en`. `ovf_sticky` rises on that same cycle.
- Values after reset: state IDLE, `in_ready`=1, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `ovf_pulse`=0, `ovf_sticky`=0, `retire_cnt`=0.
- Reset while in SECOND discards the pending R0 write; no `wr_en` is produced after reset.
- Reset has priority over `in_valid` and `ovf_clr` in the same cycle.

## Structure
- Shared package `alu_pkg` holds:
  - ctrl code constants: `ALU_ADD`, `ALU_SUB`, `ALU_MUL`, `ALU_DIV`, `ALU_ANDI`, `ALU_ORI`, `ALU_ADDNF`
  - the two-value state enum
  - helper functions `is_two_write(ctrl)` and `is_ovf_checked(ctrl)`, shared with the decoder
- No sub-module; a single module.

## Test plan
- ADD: ctrl=1, rd=3, result=0x0005, ovf=0 → next cycle `wr_en`=1, addr=3, data=0x0005; `retire_cnt`=1.
- MUL: ctrl=4, rd=2, result=0x2000, r0=0x0001 → write (2, 0x2000), then (0, 0x0001); `in_ready` low for one cycle; a second `in_valid` held across the stall is accepted only afterwards.
- Overflow: ctrl=2, rd=5, ovf=1 → no `wr_en`, `ovf_pulse` for one cycle, `ovf_sticky`=1. Pulse `ovf_clr` alongside another overflowing ADD → sticky stays 1. A lone `ovf_clr` → 0.
- DIV with rd=0: result=0x0007, r0=0x0003 → writes (0, 0x0007) then (0, 0x0003). Unused ctrl=D → no write, count increments.
- Reset asserted in SECOND after MUL → no R0 write; all outputs at reset values the next cycle. Also run 65536 transfers and check `retire_cnt` wraps to 0.
